// File: rtl/otp_pkg.sv
// Shared constants and types for the OTP read arbiter: address/data widths,
// key-range limit and the sequencer state encoding.
package otp_pkg;

    localparam int OTP_ADDR_W     = 2;
    localparam int OTP_DATA_W     = 8;
    localparam int KEY_LOCK_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/otp_rr_pick.sv
// Combinational round-robin selector: searches from last_i+1, wrapping at
// NUM_REQ, and returns the first active request as one-hot plus index.
module otp_rr_pick
    import otp_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/otp_read_arb.sv
// Shares the byte-wide OTP read port among NUM_REQ requesters: round-robin
// grant, one read in flight, per-owner response, sticky key-range lock.
module otp_read_arb
    import otp_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = OTP_ADDR_W,
    parameter int DATA_W     = OTP_DATA_W,
    parameter int RD_LAT     = 0,
    parameter int LOCK_LIMIT = KEY_LOCK_LIMIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    input  logic                      lock,
    output logic                      locked,
    output logic                      otp_read_en,
    output logic [ADDR_W-1:0]         otp_read_addr,
    input  logic [DATA_W-1:0]         otp_read_data
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_e              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [NUM_REQ-1:0]  owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                locked_q;
    logic                otp_en_q;
    logic [ADDR_W-1:0]   otp_addr_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;

    logic [NUM_REQ-1:0]  win_gnt;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [ADDR_W-1:0]   win_addr;
    logic                refuse;

    otp_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i  (req_valid),
        .last_i (rr_ptr_q),
        .gnt_o  (win_gnt),
        .idx_o  (win_idx),
        .any_o  (win_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign win_addr  = addr_arr[win_idx];
    // A lock arriving in the grant cycle already counts against that grant.
    assign refuse    = (locked_q || lock) && (win_idx != '0) && (int'(win_addr) < LOCK_LIMIT);
    assign req_ready = (state_q == IDLE) ? win_gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            locked_q    <= 1'b0;
            otp_en_q    <= 1'b0;
            otp_addr_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch reads pre-edge state.
            locked_q    <= locked_q | lock;
            otp_en_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        rr_ptr_q <= win_idx;
                        owner_q  <= win_gnt;
                        if (refuse) begin
                            rsp_valid_q <= win_gnt;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            // Only accepted reads drive the bus address; refused key addresses never appear.
                            otp_addr_q <= win_addr;
                            otp_en_q   <= 1'b1;
                            state_q    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (RD_LAT == 0) begin
                        rsp_valid_q <= owner_q;
                        rsp_data_q  <= otp_read_data;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q   <= LAT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= owner_q;
                        rsp_data_q  <= otp_read_data;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign locked        = locked_q;
    assign otp_read_en   = otp_en_q;
    assign otp_read_addr = otp_addr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_otp_read_arb.sv
// Scoreboard bench for otp_read_arb: one instance with RD_LAT=0, one with
// RD_LAT=3, each fed by a small OTP memory model.
module tb_otp_read_arb;

    localparam int LAT0 = 0;
    localparam int LAT3 = 3;

    typedef struct {
        int         cyc;
        logic [2:0] v;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    typedef struct {
        int         cyc;
        logic [1:0] addr;
    } en_t;

    logic       clk;
    logic       rst;
    logic [2:0] rv0, rv3, rdy0, rdy3, rspv0, rspv3;
    logic [5:0] ra0, ra3;
    logic       lk0, lk3, lkd0, lkd3, rspe0, rspe3, en0, en3;
    logic [1:0] oa0, oa3;
    logic [7:0] rspd0, rspd3, od0, od3;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    rsp_t rsp_q   [2][$];
    en_t  en_q    [2][$];
    int   gnt_log [2][$];
    int   gcyc    [2][$];
    logic lkm     [2];

    logic [2:0] en_pipe = '0;
    logic [7:0] noise   = 8'h5A;
    logic [2:0] pv0 = '0, pr0 = '0, pv3 = '0, pr3 = '0;
    logic       rst_q = 1'b0;

    otp_read_arb #(.NUM_REQ(3), .ADDR_W(2), .DATA_W(8), .RD_LAT(LAT0), .LOCK_LIMIT(4)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_addr(ra0), .req_ready(rdy0),
        .rsp_valid(rspv0), .rsp_data(rspd0), .rsp_err(rspe0), .lock(lk0), .locked(lkd0),
        .otp_read_en(en0), .otp_read_addr(oa0), .otp_read_data(od0)
    );

    otp_read_arb #(.NUM_REQ(3), .ADDR_W(2), .DATA_W(8), .RD_LAT(LAT3), .LOCK_LIMIT(4)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_addr(ra3), .req_ready(rdy3),
        .rsp_valid(rspv3), .rsp_data(rspd3), .rsp_err(rspe3), .lock(lk3), .locked(lkd3),
        .otp_read_en(en3), .otp_read_addr(oa3), .otp_read_data(od3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] otp_val(input logic [1:0] a);
        case (a)
            2'd0:    return 8'h11;
            2'd1:    return 8'h3C;
            2'd2:    return 8'hA5;
            default: return 8'h5C;
        endcase
    endfunction

    // Same-cycle OTP for dut0; dut3 sees valid data only RD_LAT cycles after en.
    assign od0 = en0 ? otp_val(oa0) : 8'hEE;
    assign od3 = otp_val(oa3) ^ (en_pipe[2] ? 8'h00 : noise);

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_pipe <= {en_pipe[1:0], en3};
        noise   <= 8'($urandom_range(1, 255));
    end

    // Requesters must hold req_valid until req_ready.
    always @(posedge clk) begin
        if (!rst && !rst_q) begin
            assert ((pv0 & ~pr0 & ~rv0) == 3'b000) else $error("dut0 req_valid dropped before req_ready");
            assert ((pv3 & ~pr3 & ~rv3) == 3'b000) else $error("dut3 req_valid dropped before req_ready");
        end
        pv0   <= rv0;
        pr0   <= rdy0;
        pv3   <= rv3;
        pr3   <= rdy3;
        rst_q <= rst;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mon(input int d);
        logic [2:0] r, vin, rv;
        logic [5:0] ra;
        logic       lk, lkd, en, re, refused;
        logic [1:0] oa, addr;
        logic [7:0] rd;
        int         lat, idx;
        string      p;
        rsp_t       er;
        en_t        ee;
        if (d == 0) begin
            r = rdy0; vin = rv0; ra = ra0; lk = lk0; lkd = lkd0; en = en0; oa = oa0;
            rv = rspv0; rd = rspd0; re = rspe0; lat = LAT0; p = "d0_";
        end else begin
            r = rdy3; vin = rv3; ra = ra3; lk = lk3; lkd = lkd3; en = en3; oa = oa3;
            rv = rspv3; rd = rspd3; re = rspe3; lat = LAT3; p = "d3_";
        end
        check({p, "locked"}, {31'd0, lkd}, {31'd0, lkm[d]});
        if (r != 3'b000) begin
            idx  = r[0] ? 0 : (r[1] ? 1 : 2);
            addr = ra[idx*2 +: 2];
            check({p, "ready_onehot"}, {31'd0, $onehot(r)}, 32'd1);
            check({p, "ready_without_valid"}, {29'd0, r & ~vin}, 32'd0);
            gnt_log[d].push_back(idx);
            gcyc[d].push_back(cyc);
            refused = (lkm[d] || lk) && (idx != 0) && (int'(addr) < 4);
            if (refused) begin
                rsp_q[d].push_back('{cyc: cyc + 1, v: 3'(1 << idx), data: 8'h00, err: 1'b1});
            end else begin
                en_q[d].push_back('{cyc: cyc + 1, addr: addr});
                rsp_q[d].push_back('{cyc: cyc + 2 + lat, v: 3'(1 << idx), data: otp_val(addr), err: 1'b0});
            end
        end
        if (en) begin
            if (en_q[d].size() == 0) begin
                check({p, "spurious_en"}, {31'd0, en}, 32'd0);
            end else begin
                ee = en_q[d].pop_front();
                check({p, "en_cycle"}, cyc, ee.cyc);
                check({p, "en_addr"}, {30'd0, oa}, {30'd0, ee.addr});
            end
        end
        if (rv != 3'b000) begin
            if (rsp_q[d].size() == 0) begin
                check({p, "spurious_rsp"}, {29'd0, rv}, 32'd0);
            end else begin
                er = rsp_q[d].pop_front();
                check({p, "rsp_cycle"}, cyc, er.cyc);
                check({p, "rsp_valid"}, {29'd0, rv}, {29'd0, er.v});
                check({p, "rsp_data"}, {24'd0, rd}, {24'd0, er.data});
                check({p, "rsp_err"}, {31'd0, re}, {31'd0, er.err});
            end
        end
        if (lk) lkm[d] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    task automatic set_in(input int d, input logic [2:0] v, input logic [5:0] a);
        if (d == 0) begin
            rv0 = v; ra0 = a;
        end else begin
            rv3 = v; ra3 = a;
        end
    endtask

    // Holds each masked request until it has been granted n_each times.
    task automatic drive_reqs(input int d, input logic [2:0] mask, input logic [5:0] addrs, input int n_each);
        int         cnt [3] = '{0, 0, 0};
        logic [2:0] v, r;
        int         t;
        v = mask;
        t = 0;
        set_in(d, v, addrs);
        while (v != 3'b000 && t < 100) begin
            @(negedge clk);
            r = (d == 0) ? rdy0 : rdy3;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (r[i]) begin
                    cnt[i]++;
                    if (cnt[i] >= n_each) v[i] = 1'b0;
                end
            end
            set_in(d, v, addrs);
            t++;
        end
        if (v != 3'b000) begin
            check("drive_timeout", {29'd0, v}, 32'd0);
            set_in(d, 3'b000, addrs);
        end
    endtask

    task automatic wait_idle(input int d);
        int t;
        t = 0;
        while ((rsp_q[d].size() != 0 || en_q[d].size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", rsp_q[d].size() + en_q[d].size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_en0",     {31'd0, en0},   32'd0);
        check("rst_addr0",   {30'd0, oa0},   32'd0);
        check("rst_rspv0",   {29'd0, rspv0}, 32'd0);
        check("rst_rspd0",   {24'd0, rspd0}, 32'd0);
        check("rst_err0",    {31'd0, rspe0}, 32'd0);
        check("rst_locked0", {31'd0, lkd0},  32'd0);
        check("rst_en3",     {31'd0, en3},   32'd0);
        check("rst_addr3",   {30'd0, oa3},   32'd0);
        check("rst_rspv3",   {29'd0, rspv3}, 32'd0);
        check("rst_rspd3",   {24'd0, rspd3}, 32'd0);
        check("rst_err3",    {31'd0, rspe3}, 32'd0);
        check("rst_locked3", {31'd0, lkd3},  32'd0);
        for (int d = 0; d < 2; d++) begin
            rsp_q[d].delete();
            en_q[d].delete();
            gnt_log[d].delete();
            gcyc[d].delete();
            lkm[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        check("rst_ready0", {29'd0, rdy0}, 32'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_ord [6] = '{0, 1, 2, 0, 1, 2};
        rst = 1'b0;
        rv0 = '0; ra0 = '0; lk0 = 1'b0;
        rv3 = '0; ra3 = '0; lk3 = 1'b0;
        lkm[0] = 1'b0;
        lkm[1] = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // All three requesting continuously from reset: 0,1,2,0,1,2 every 2 cycles.
        drive_reqs(0, 3'b111, {2'd3, 2'd2, 2'd1}, 2);
        wait_idle(0);
        check("grant_count", gnt_log[0].size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < gnt_log[0].size()) check("grant_order", gnt_log[0][i], exp_ord[i]);
        end
        for (int i = 1; i < gcyc[0].size(); i++) begin
            check("grant_spacing", gcyc[0][i] - gcyc[0][i-1], 32'd2);
        end

        // Single request 1 @ addr 2.
        gnt_log[0].delete();
        drive_reqs(0, 3'b010, {2'd0, 2'd2, 2'd0}, 1);
        wait_idle(0);
        check("single_grant", (gnt_log[0].size() > 0) ? gnt_log[0][0] : -1, 32'd1);

        // Lock pulse, then requester 2 refused and requester 0 served.
        lk0 = 1'b1;
        @(posedge clk);
        #1;
        lk0 = 1'b0;
        check("locked_after_pulse", {31'd0, lkd0}, 32'd1);
        drive_reqs(0, 3'b100, {2'd1, 2'd0, 2'd0}, 1);
        wait_idle(0);
        drive_reqs(0, 3'b001, {2'd0, 2'd0, 2'd1}, 1);
        wait_idle(0);

        // RD_LAT=3: requester 0 @ addr 3, early data is noise.
        drive_reqs(1, 3'b001, {2'd0, 2'd0, 2'd3}, 1);
        wait_idle(1);

        // Reset while a read sits in WAIT: no response, then rr restarts.
        drive_reqs(1, 3'b001, {2'd0, 2'd0, 2'd2}, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        drive_reqs(1, 3'b110, {2'd2, 2'd3, 2'd0}, 1);
        wait_idle(1);
        check("post_rst_first", (gnt_log[1].size() > 0) ? gnt_log[1][0] : -1, 32'd1);
        check("post_rst_second", (gnt_log[1].size() > 1) ? gnt_log[1][1] : -1, 32'd2);

        // Lock arriving during WAIT does not abort the granted read.
        drive_reqs(1, 3'b010, {2'd0, 2'd0, 2'd0}, 1);
        @(posedge clk);
        #1;
        lk3 = 1'b1;
        @(posedge clk);
        #1;
        lk3 = 1'b0;
        wait_idle(1);
        check("locked_mid_read", {31'd0, lkd3}, 32'd1);

        // Lock in the same cycle as the grant refuses it.
        do_reset();
        lk3 = 1'b1;
        drive_reqs(1, 3'b010, {2'd0, 2'd0, 2'd0}, 1);
        lk3 = 1'b0;
        wait_idle(1);

        repeat (4) @(posedge clk);
        #1;
        check("final_rsp_q0", rsp_q[0].size(), 32'd0);
        check("final_rsp_q3", rsp_q[1].size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
